// File: rtl/frame_state_latch_if.sv
// ============================================================================
//  Module   : frame_state_latch_if
//  Brief    : CDC word / frame timing in, committed positions and status out.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface frame_state_latch_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic [X_WIDTH+3*Y_WIDTH-1:0] i_state;
    logic                         i_frame_start;
    logic                         i_vblank;
    logic [X_WIDTH-1:0]           o_ball_x;
    logic [Y_WIDTH-1:0]           o_ball_y;
    logic [Y_WIDTH-1:0]           o_paddle_l_y;
    logic [Y_WIDTH-1:0]           o_paddle_r_y;
    logic                         o_frame_valid;
    logic                         o_update;
    logic                         o_stale;

    modport master (
        output i_state, i_frame_start, i_vblank,
        input  o_ball_x, o_ball_y, o_paddle_l_y, o_paddle_r_y,
        input  o_frame_valid, o_update, o_stale
    );

    modport slave (
        input  i_state, i_frame_start, i_vblank,
        output o_ball_x, o_ball_y, o_paddle_l_y, o_paddle_r_y,
        output o_frame_valid, o_update, o_stale
    );
endinterface

`default_nettype wire

// File: rtl/frame_state_latch.sv
// ============================================================================
//  Module   : frame_state_latch
//  Brief    : Qualifies the CDC position word for stability and commits it only
//             at frame start or during vertical blank.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module frame_state_latch #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic           i_clk,
    input  wire logic           rst,
    frame_state_latch_if.slave  bus
);
    localparam int C_WORD_W = X_WIDTH + 3 * Y_WIDTH;
    localparam int C_CNT_W  = 4;
    localparam logic [C_CNT_W-1:0] C_STABLE = C_CNT_W'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e                fsm_q,         fsm_d;
    logic [C_WORD_W-1:0]   shadow_q,      shadow_d;
    logic [C_CNT_W-1:0]    cnt_q,         cnt_d;
    logic [X_WIDTH-1:0]    ball_x_q,      ball_x_d;
    logic [Y_WIDTH-1:0]    ball_y_q,      ball_y_d;
    logic [Y_WIDTH-1:0]    paddle_l_y_q,  paddle_l_y_d;
    logic [Y_WIDTH-1:0]    paddle_r_y_q,  paddle_r_y_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  update_q,      update_d;
    logic                  stale_q,       stale_d;
    logic                  w_stable;
    logic                  w_commit;

    assign w_stable = (cnt_q == C_STABLE);

    // Any difference from the shadow restarts the count; otherwise count up and saturate.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        if (bus.i_state != shadow_q) begin
            shadow_d = bus.i_state;
            cnt_d    = '0;
        end else if (!w_stable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        w_commit = 1'b0;
        stale_d  = stale_q;
        case (fsm_q)
            ST_IDLE: begin
                if (bus.i_frame_start) begin
                    if (w_stable) w_commit = 1'b1;
                    else          fsm_d    = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (bus.i_frame_start) begin
                    if (w_stable) begin
                        w_commit = 1'b1;
                        fsm_d    = ST_IDLE;
                    end
                end else if (bus.i_vblank) begin
                    if (w_stable) begin
                        w_commit = 1'b1;
                        fsm_d    = ST_IDLE;
                    end
                end else begin
                    // Blank ended without a usable word: this frame reuses the last commit.
                    stale_d = 1'b1;
                    fsm_d   = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (w_commit) stale_d = 1'b0;
    end

    // Commit always takes the shadow, so a word arriving on the commit edge waits its turn.
    always_comb begin
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        paddle_l_y_d  = paddle_l_y_q;
        paddle_r_y_d  = paddle_r_y_q;
        frame_valid_d = frame_valid_q | w_commit;
        update_d      = w_commit;
        if (w_commit) begin
            ball_x_d     = shadow_q[C_WORD_W-1 -: X_WIDTH];
            ball_y_d     = shadow_q[3*Y_WIDTH-1 -: Y_WIDTH];
            paddle_l_y_d = shadow_q[2*Y_WIDTH-1 -: Y_WIDTH];
            paddle_r_y_d = shadow_q[Y_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            fsm_q         <= ST_IDLE;
            shadow_q      <= '0;
            cnt_q         <= '0;
            ball_x_q      <= '0;
            ball_y_q      <= '0;
            paddle_l_y_q  <= '0;
            paddle_r_y_q  <= '0;
            frame_valid_q <= 1'b0;
            update_q      <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            shadow_q      <= shadow_d;
            cnt_q         <= cnt_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            paddle_l_y_q  <= paddle_l_y_d;
            paddle_r_y_q  <= paddle_r_y_d;
            frame_valid_q <= frame_valid_d;
            update_q      <= update_d;
            stale_q       <= stale_d;
        end
    end

    assign bus.o_ball_x      = ball_x_q;
    assign bus.o_ball_y      = ball_y_q;
    assign bus.o_paddle_l_y  = paddle_l_y_q;
    assign bus.o_paddle_r_y  = paddle_r_y_q;
    assign bus.o_frame_valid = frame_valid_q;
    assign bus.o_update      = update_q;
    assign bus.o_stale       = stale_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_state_latch.sv
// ============================================================================
//  Module   : tb_frame_state_latch
//  Brief    : Directed vector table plus corner sequences for frame_state_latch.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_state_latch;
    localparam int XW = 10;
    localparam int YW = 10;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    frame_state_latch_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

    frame_state_latch #(
        .X_WIDTH      (XW),
        .Y_WIDTH      (YW),
        .STABLE_CYCLES(4)
    ) dut (
        .i_clk(clk),
        .rst  (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] pl;
        logic [9:0] pr;
        int         hold;
        logic       commit_now;
    } vec_t;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [9:0] bx, by, pl, pr);
        bus.i_state = {bx, by, pl, pr};
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [39:0] pos,
                             input logic fv, input logic upd, input logic st);
        check({name, " pos"},   {bus.o_ball_x, bus.o_ball_y, bus.o_paddle_l_y, bus.o_paddle_r_y}, pos);
        check({name, " valid"}, bus.o_frame_valid, fv);
        check({name, " update"}, bus.o_update, upd);
        check({name, " stale"}, bus.o_stale, st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vec [5];
        logic [39:0] prev;
        logic [39:0] expv;

        vec[0] = '{bx: 10'd100,  by: 10'd200,  pl: 10'd50,   pr: 10'd300,  hold: 10, commit_now: 1'b1};
        vec[1] = '{bx: 10'd0,    by: 10'd0,    pl: 10'd0,    pr: 10'd0,    hold: 5,  commit_now: 1'b1};
        vec[2] = '{bx: 10'd1023, by: 10'd1023, pl: 10'd1023, pr: 10'd1023, hold: 6,  commit_now: 1'b1};
        vec[3] = '{bx: 10'd513,  by: 10'd2,    pl: 10'd1022, pr: 10'd1,    hold: 4,  commit_now: 1'b0};
        vec[4] = '{bx: 10'h155,  by: 10'h2AA,  pl: 10'h0F0,  pr: 10'h30F,  hold: 5,  commit_now: 1'b1};

        rst_n             = 1'b0;
        bus.i_state       = '0;
        bus.i_frame_start = 1'b0;
        bus.i_vblank      = 1'b0;
        repeat (3) cyc();
        check_all("reset", 40'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Table: hold a word, pulse frame start, expect commit now or one edge later.
        prev = '0;
        for (int i = 0; i < 5; i++) begin
            set_word(vec[i].bx, vec[i].by, vec[i].pl, vec[i].pr);
            bus.i_vblank      = 1'b1;
            bus.i_frame_start = 1'b0;
            repeat (vec[i].hold) cyc();
            bus.i_frame_start = 1'b1;
            cyc();
            bus.i_frame_start = 1'b0;
            expv = {vec[i].bx, vec[i].by, vec[i].pl, vec[i].pr};
            if (!vec[i].commit_now) begin
                check_all($sformatf("vec%0d wait", i), prev, 1'b1, 1'b0, 1'b0);
                cyc();
            end
            check_all($sformatf("vec%0d commit", i), expv, 1'b1, 1'b1, 1'b0);
            cyc();
            check_all($sformatf("vec%0d after", i), expv, 1'b1, 1'b0, 1'b0);
            prev = expv;
        end

        // Pending commit: word changes just before frame start, commits 4 edges later.
        set_word(10'd101, 10'd200, 10'd50, 10'd300);
        cyc();
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        check_all("pend fs", prev, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_all($sformatf("pend wait%0d", k), prev, 1'b1, 1'b0, 1'b0);
        end
        cyc();
        prev = {10'd101, 10'd200, 10'd50, 10'd300};
        check_all("pend commit", prev, 1'b1, 1'b1, 1'b0);
        cyc();
        check_all("pend after", prev, 1'b1, 1'b0, 1'b0);

        // Stale frame: word toggles through the whole blank.
        bus.i_vblank = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_word((k % 2) ? 10'd6 : 10'd5, 10'd200, 10'd50, 10'd300);
            bus.i_frame_start = (k == 1);
            cyc();
            check_all($sformatf("stale blank%0d", k), prev, 1'b1, 1'b0, 1'b0);
        end
        bus.i_frame_start = 1'b0;
        bus.i_vblank      = 1'b0;
        set_word(10'd5, 10'd200, 10'd50, 10'd300);
        cyc();
        check_all("stale set", prev, 1'b1, 1'b0, 1'b1);
        set_word(10'd9, 10'd10, 10'd11, 10'd12);
        for (int k = 0; k < 8; k++) begin
            cyc();
            check_all($sformatf("stale hold%0d", k), prev, 1'b1, 1'b0, 1'b1);
        end
        bus.i_vblank      = 1'b1;
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        prev = {10'd9, 10'd10, 10'd11, 10'd12};
        check_all("stale clear", prev, 1'b1, 1'b1, 1'b0);

        // Simultaneous change and commit: old shadow (7) wins, 8 follows next frame.
        set_word(10'd7, 10'd1, 10'd2, 10'd3);
        repeat (5) cyc();
        set_word(10'd8, 10'd1, 10'd2, 10'd3);
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        prev = {10'd7, 10'd1, 10'd2, 10'd3};
        check_all("simul old", prev, 1'b1, 1'b1, 1'b0);
        repeat (6) cyc();
        check_all("simul gap", prev, 1'b1, 1'b0, 1'b0);
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        prev = {10'd8, 10'd1, 10'd2, 10'd3};
        check_all("simul new", prev, 1'b1, 1'b1, 1'b0);

        // Active video, no frame start: outputs must not move.
        bus.i_vblank = 1'b0;
        set_word(10'd200, 10'd300, 10'd400, 10'd500);
        for (int k = 0; k < 50; k++) begin
            cyc();
            check($sformatf("midframe pos%0d", k),
                  {bus.o_ball_x, bus.o_ball_y, bus.o_paddle_l_y, bus.o_paddle_r_y}, prev);
            check($sformatf("midframe upd%0d", k), bus.o_update, 1'b0);
        end

        // Reset while PENDING, then recommit zeros.
        bus.i_vblank = 1'b1;
        set_word(10'd1, 10'd1, 10'd1, 10'd1);
        cyc();
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        check_all("rst pend", prev, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("rst async", 40'd0, 1'b0, 1'b0, 1'b0);
        bus.i_state  = '0;
        bus.i_vblank = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_all($sformatf("rst idle%0d", k), 40'd0, 1'b0, 1'b0, 1'b0);
        end
        bus.i_frame_start = 1'b1;
        cyc();
        bus.i_frame_start = 1'b0;
        check_all("rst commit", 40'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        check_all("rst after", 40'd0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
